// File: rtl/wb_camera_pkg.sv
// Shared definitions for the wb_camera capture peripheral: register map, bit indices,
// capture FSM encoding and the STATUS word builder.
package wb_camera_pkg;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegLevel  = 2'd2;
  localparam logic [1:0] RegData   = 2'd3;

  localparam int unsigned CtrlStart     = 0;
  localparam int unsigned CtrlSensorRst = 1;
  localparam int unsigned CtrlPwdn      = 2;
  localparam int unsigned CtrlIrqEn     = 3;

  localparam int unsigned StatBusy  = 0;
  localparam int unsigned StatDone  = 1;
  localparam int unsigned StatOvf   = 2;
  localparam int unsigned StatEmpty = 3;
  localparam int unsigned StatFull  = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitVs  = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cam_state_e;

  function automatic logic [31:0] status_word(input logic busy, input logic done,
                                              input logic ovf, input logic empty,
                                              input logic full);
    logic [31:0] w;
    w            = '0;
    w[StatBusy]  = busy;
    w[StatDone]  = done;
    w[StatOvf]   = ovf;
    w[StatEmpty] = empty;
    w[StatFull]  = full;
    return w;
  endfunction

endpackage

// File: rtl/cam_fifo.sv
// Single-clock 32-bit FIFO with first-word fall-through output. A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module cam_fifo #(
  parameter int unsigned depth_log2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   level
);

  localparam int unsigned Depth = 1 << depth_log2;

  logic [31:0]           mem_q [Depth];
  logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [depth_log2:0]   cnt_q, cnt_d;
  logic                  do_wr, do_rd;

  assign empty = (cnt_q == '0);
  // Count never exceeds Depth, so the MSB alone marks full.
  assign full  = cnt_q[depth_log2];
  assign level = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_rd = pop & ~empty;
  assign do_wr = push & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_camera.sv
// Wishbone camera-capture slave: drives XCLK, captures one frame of parallel sensor
// bytes per start request, packs them big-endian into words and buffers them in a FIFO.
module wb_camera
  import wb_camera_pkg::*;
#(
  parameter int unsigned fifo_depth_log2 = 9,
  parameter int unsigned xclk_div        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        cam_xclk,
  output logic        cam_reset_n,
  output logic        cam_pwdn,
  output logic        intr
);

  localparam logic [15:0] XclkLast = 16'(xclk_div - 1);

  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:4], wb_sel_i};

  cam_state_e  state_q, state_d;
  logic [3:1]  ctrl_q, ctrl_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        done_q, done_d, ovf_q, ovf_d, seen_rise_q, seen_rise_d;
  logic [15:0] line_cnt_q, line_cnt_d, xclk_cnt_q, xclk_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;
  logic        xclk_q, xclk_d;
  logic        vs_prev_q, vs_prev_d, href_prev_q, href_prev_d;

  logic        pclk_s1_q, pclk_s2_q, pclk_s3_q, vs_s1_q, vs_s2_q, href_s1_q, href_s2_q;
  logic [7:0]  data_s1_q, data_s2_q;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_dout;
  logic [fifo_depth_log2:0] fifo_level;

  logic req, ctrl_wr, status_wr, busy, pclk_edge, vs_rise, vs_fall, href_fall, start;

  assign req       = wb_stb_i & wb_cyc_i & ~ack_q;
  assign ctrl_wr   = req & wb_we_i & (wb_adr_i[3:2] == RegCtrl);
  assign status_wr = req & wb_we_i & (wb_adr_i[3:2] == RegStatus);
  assign busy      = (state_q == StWaitVs) | (state_q == StCapture);
  assign start     = ctrl_wr & wb_dat_i[CtrlStart] & (state_q == StIdle);

  assign pclk_edge = pclk_s2_q & ~pclk_s3_q;
  assign vs_rise   = pclk_edge & vs_s2_q & ~vs_prev_q;
  assign vs_fall   = pclk_edge & ~vs_s2_q & vs_prev_q;
  assign href_fall = pclk_edge & ~href_s2_q & href_prev_q;

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign cam_xclk    = xclk_q;
  assign cam_reset_n = ~ctrl_q[CtrlSensorRst];
  assign cam_pwdn    = ctrl_q[CtrlPwdn];
  assign intr        = done_q & ctrl_q[CtrlIrqEn];

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    ack_d       = req;
    dat_d       = '0;
    done_d      = done_q;
    ovf_d       = ovf_q;
    seen_rise_d = seen_rise_q;
    line_cnt_d  = line_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    vs_prev_d   = vs_prev_q;
    href_prev_d = href_prev_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    xclk_d      = xclk_q;
    xclk_cnt_d  = xclk_cnt_q + 16'd1;

    if (xclk_cnt_q == XclkLast) begin
      xclk_cnt_d = '0;
      xclk_d     = ~xclk_q;
    end

    if (pclk_edge) begin
      vs_prev_d   = vs_s2_q;
      href_prev_d = href_s2_q;
    end

    if (ctrl_wr) ctrl_d = wb_dat_i[3:1];
    if (status_wr) begin
      if (wb_dat_i[StatDone]) done_d = 1'b0;
      if (wb_dat_i[StatOvf])  ovf_d  = 1'b0;
    end

    if (req && !wb_we_i) begin
      case (wb_adr_i[3:2])
        RegCtrl:   dat_d = {28'd0, ctrl_q, 1'b0};
        RegStatus: dat_d = status_word(busy, done_q, ovf_q, fifo_empty, fifo_full);
        RegLevel:  dat_d = {line_cnt_q, 16'(fifo_level)};
        default: begin
          if (!fifo_empty) begin
            dat_d    = fifo_dout;
            fifo_pop = 1'b1;
          end
        end
      endcase
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StWaitVs;
          line_cnt_d  = '0;
          byte_cnt_d  = '0;
          word_d      = '0;
          ovf_d       = 1'b0;
          seen_rise_d = 1'b0;
        end
      end
      StWaitVs: begin
        if (vs_rise) seen_rise_d = 1'b1;
        if (seen_rise_q && vs_fall) state_d = StCapture;
      end
      StCapture: begin
        if (pclk_edge && href_s2_q) begin
          word_d     = {word_q[15:0], data_s2_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            fifo_push = 1'b1;
            if (fifo_full && !fifo_pop) ovf_d = 1'b1;
          end
        end
        if (href_fall) line_cnt_d = line_cnt_q + 16'd1;
        if (vs_rise) state_d = StDone;
      end
      default: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    endcase

    // Asserting sensor reset while busy abandons the frame without flagging done.
    if (ctrl_wr && wb_dat_i[CtrlSensorRst] && busy) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ctrl_q      <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      seen_rise_q <= 1'b0;
      line_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      xclk_q      <= 1'b0;
      xclk_cnt_q  <= '0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      pclk_s1_q   <= 1'b0;
      pclk_s2_q   <= 1'b0;
      pclk_s3_q   <= 1'b0;
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      href_s1_q   <= 1'b0;
      href_s2_q   <= 1'b0;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      seen_rise_q <= seen_rise_d;
      line_cnt_q  <= line_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      xclk_q      <= xclk_d;
      xclk_cnt_q  <= xclk_cnt_d;
      vs_prev_q   <= vs_prev_d;
      href_prev_q <= href_prev_d;
      pclk_s1_q   <= cam_pclk;
      pclk_s2_q   <= pclk_s1_q;
      pclk_s3_q   <= pclk_s2_q;
      vs_s1_q     <= cam_vsync;
      vs_s2_q     <= vs_s1_q;
      href_s1_q   <= cam_href;
      href_s2_q   <= href_s1_q;
      data_s1_q   <= cam_data;
      data_s2_q   <= data_s1_q;
    end
  end

  cam_fifo #(
    .depth_log2(fifo_depth_log2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({word_q, data_s2_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule
